mem_responder: RTL and testbench

Memory-side responder for the SAP-2 address path. It accepts the 16-bit address held by the memory address register plus a request strobe, inserts a fixed number of wait states, performs one read or write into an internal word array, and returns a one-cycle acknowledge with read data. It sits between the MAR/bus control and the CPU data bus, and forms the memory end of the MAR address interface.

---
 rtl/mem_responder_if.sv | 25 ++
 rtl/mem_responder.sv | 112 +++++++++++
 tb/tb_mem_responder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bus between the MAR-side requester and the memory responder.
// The master drives address, strobe and write data; the slave returns data and status.
interface mem_responder_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
) ();
    logic [ADDR_W-1:0] iAddr;
    logic              iReq;
    logic              iWe;
    logic [DATA_W-1:0] iWData;
    logic [DATA_W-1:0] oRData;
    logic              oAck;
    logic              oBusy;
    logic              oErr;

    modport master (
        output iAddr, iReq, iWe, iWData,
        input  oRData, oAck, oBusy, oErr
    );

    modport slave (
        input  iAddr, iReq, iWe, iWData,
        output oRData, oAck, oBusy, oErr
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: wait states, one access into a word array, one-cycle ack.
// Optional write protection of the low region is enabled by MEM_ROM_PROTECT_EN.
module mem_responder #(
    parameter int unsigned       ADDR_W      = 16,
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       DEPTH_LOG2  = 11,
    parameter int unsigned       WAIT_CYCLES = 2,
    parameter logic [ADDR_W-1:0] ROM_TOP     = 16'h07FF
) (
    input logic             iClk,
    input logic             iRst,
    mem_responder_if.slave  bus
);
    localparam int unsigned CntW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e                state_q;
    logic [CntW-1:0]       cnt_q;
    logic [DEPTH_LOG2-1:0] addr_q;
    logic                  we_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W-1:0]     rdata_q;
    logic                  ack_q;
    logic                  busy_q;
    logic                  err_q;

    // Contents are deliberately not reset.
    logic [DATA_W-1:0]     mem_q [2**DEPTH_LOG2];

    logic                  rom_hit;
    logic                  access;
    logic                  mem_we;

`ifdef MEM_ROM_PROTECT_EN
    logic [ADDR_W-1:0]     addr_full_q;
    assign rom_hit = we_q && (addr_full_q <= ROM_TOP);
`else
    logic                  unused_addr_hi;
    assign unused_addr_hi = ^{bus.iAddr[ADDR_W-1:DEPTH_LOG2], ROM_TOP};
    assign rom_hit        = 1'b0;
`endif

    assign access = (state_q == StWait) && (cnt_q == '0);
    assign mem_we = access && we_q && !rom_hit;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef MEM_ROM_PROTECT_EN
            addr_full_q <= '0;
`endif
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.iReq) begin
                        addr_q      <= bus.iAddr[DEPTH_LOG2-1:0];
`ifdef MEM_ROM_PROTECT_EN
                        addr_full_q <= bus.iAddr;
`endif
                        we_q        <= bus.iWe;
                        wdata_q     <= bus.iWData;
                        cnt_q       <= CntW'(WAIT_CYCLES);
                        busy_q      <= 1'b1;
                        state_q     <= StWait;
                    end
                end
                StWait: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q <= StAck;
                        ack_q   <= 1'b1;
                        err_q   <= rom_hit;
                        // A suppressed write leaves the previous read data visible.
                        if (!we_q) begin
                            rdata_q <= mem_q[addr_q];
                        end else if (!rom_hit) begin
                            rdata_q <= wdata_q;
                        end
                    end
                end
                StAck: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (mem_we) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign bus.oRData = rdata_q;
    assign bus.oAck   = ack_q;
    assign bus.oBusy  = busy_q;
    assign bus.oErr   = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
// Expectations follow MEM_ROM_PROTECT_EN when the bench is built with it.
module tb_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_W(16), .DATA_W(8)) bus  ();
    mem_responder_if #(.ADDR_W(16), .DATA_W(8)) bus0 ();

    mem_responder #(.WAIT_CYCLES(2)) u_dut  (.iClk(clk), .iRst(rst), .bus(bus));
    mem_responder #(.WAIT_CYCLES(0)) u_dut0 (.iClk(clk), .iRst(rst), .bus(bus0));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit z, input bit req, input logic [15:0] a, input bit we,
                         input logic [7:0] wd);
        if (z) begin
            bus0.iReq = req; bus0.iAddr = a; bus0.iWe = we; bus0.iWData = wd;
        end else begin
            bus.iReq = req; bus.iAddr = a; bus.iWe = we; bus.iWData = wd;
        end
    endtask

    function automatic logic [7:0] rdata_of(input bit z);
        return z ? bus0.oRData : bus.oRData;
    endfunction

    function automatic logic ack_of(input bit z);
        return z ? bus0.oAck : bus.oAck;
    endfunction

    function automatic logic busy_of(input bit z);
        return z ? bus0.oBusy : bus.oBusy;
    endfunction

    function automatic logic err_of(input bit z);
        return z ? bus0.oErr : bus.oErr;
    endfunction

    // One transaction; inputs are scrambled right after sampling to prove they are ignored.
    task automatic txn(input bit z, input logic [15:0] a, input bit we, input logic [7:0] wd,
                       output logic [7:0] rd, output int lat, output int nack,
                       output int nbusy, output bit err);
        lat = -1; nack = 0; nbusy = 0; err = 1'b0; rd = '0;
        @(negedge clk);
        drive(z, 1'b1, a, we, wd);
        @(posedge clk);
        #1;
        drive(z, 1'b0, ~a, ~we, ~wd);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (busy_of(z)) nbusy++;
            if (ack_of(z)) begin
                nack++;
                if (lat < 0) begin
                    lat = i;
                    rd  = rdata_of(z);
                    err = err_of(z);
                end
            end
        end
    endtask

    logic [7:0]  rd;
    int          lat, nack, nbusy;
    bit          err;
    logic [15:0] b2b_addr [3];
    logic [7:0]  b2b_exp  [3];
    int          ack_t    [3];
    logic [7:0]  ack_d    [3];
    int          nseen;

    initial begin
        drive(1'b0, 1'b0, 16'h0, 1'b0, 8'h0);
        drive(1'b1, 1'b0, 16'h0, 1'b0, 8'h0);
        repeat (2) @(negedge clk);
        check("rst_rdata", bus.oRData, 8'h00);
        check("rst_ack",   bus.oAck,   1'b0);
        check("rst_busy",  bus.oBusy,  1'b0);
        check("rst_err",   bus.oErr,   1'b0);
        rst = 1'b0;

        txn(1'b0, 16'h0900, 1'b1, 8'hA5, rd, lat, nack, nbusy, err);
        check("wr0900_lat",  lat,   4);
        check("wr0900_nack", nack,  1);
        check("wr0900_busy", nbusy, 4);
        check("wr0900_rd",   rd,    8'hA5);
        check("wr0900_err",  err,   1'b0);
        check("wr0900_hold", bus.oRData, 8'hA5);

        txn(1'b0, 16'h0900, 1'b0, 8'h00, rd, lat, nack, nbusy, err);
        check("rd0900_lat",  lat,   4);
        check("rd0900_nack", nack,  1);
        check("rd0900_busy", nbusy, 4);
        check("rd0900_rd",   rd,    8'hA5);

`ifdef MEM_ROM_PROTECT_EN
        txn(1'b0, 16'h1801, 1'b1, 8'h3C, rd, lat, nack, nbusy, err);
        check("alias_wr_err", err, 1'b0);
        txn(1'b0, 16'h0801, 1'b0, 8'h00, rd, lat, nack, nbusy, err);
        check("alias_rd", rd, 8'h3C);
        b2b_addr[1] = 16'h0801;
`else
        txn(1'b0, 16'h0801, 1'b1, 8'h3C, rd, lat, nack, nbusy, err);
        check("alias_wr_err", err, 1'b0);
        txn(1'b0, 16'h0001, 1'b0, 8'h00, rd, lat, nack, nbusy, err);
        check("alias_rd", rd, 8'h3C);
        b2b_addr[1] = 16'h0001;
`endif

        // 0x0810 aliases word 0x010 from outside the protected range.
        txn(1'b0, 16'h0810, 1'b1, 8'h5A, rd, lat, nack, nbusy, err);
        check("wr0810_err", err, 1'b0);
        txn(1'b0, 16'h0010, 1'b1, 8'hFF, rd, lat, nack, nbusy, err);
        check("wr0010_nack", nack, 1);
`ifdef MEM_ROM_PROTECT_EN
        check("wr0010_err", err, 1'b1);
        check("wr0010_rd",  rd,  8'h5A);
        b2b_exp[2] = 8'h5A;
`else
        check("wr0010_err", err, 1'b0);
        check("wr0010_rd",  rd,  8'hFF);
        b2b_exp[2] = 8'hFF;
`endif
        txn(1'b0, 16'h0010, 1'b0, 8'h00, rd, lat, nack, nbusy, err);
        check("rd0010_rd",  rd,  b2b_exp[2]);
        check("rd0010_err", err, 1'b0);
        txn(1'b0, 16'h0800, 1'b1, 8'h66, rd, lat, nack, nbusy, err);
        check("wr0800_err", err, 1'b0);
        check("wr0800_rd",  rd,  8'h66);

        // Reset while in WAIT aborts a write of 0x77 to 0x0900.
        @(negedge clk);
        drive(1'b0, 1'b1, 16'h0900, 1'b1, 8'h77);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00);
        @(negedge clk);
        check("pre_rst_busy", bus.oBusy, 1'b1);
        rst = 1'b1;
        #1;
        check("wait_rst_busy",  bus.oBusy,  1'b0);
        check("wait_rst_ack",   bus.oAck,   1'b0);
        check("wait_rst_rdata", bus.oRData, 8'h00);
        repeat (3) @(negedge clk);
        check("wait_rst_ack_held", bus.oAck, 1'b0);
        rst = 1'b0;
        txn(1'b0, 16'h0900, 1'b0, 8'h00, rd, lat, nack, nbusy, err);
        check("abort_rd0900", rd, 8'hA5);

        // Back-to-back reads with iReq held high; address changes in the ack cycle.
        b2b_addr[0] = 16'h0900; b2b_exp[0] = 8'hA5;
        b2b_addr[2] = 16'h0010; b2b_exp[1] = 8'h3C;
        nseen = 0;
        @(negedge clk);
        drive(1'b0, 1'b1, b2b_addr[0], 1'b0, 8'h00);
        for (int t = 0; t < 40 && nseen < 3; t++) begin
            @(negedge clk);
            if (bus.oBusy && !bus.oAck && nseen < 3) bus.iAddr = ~b2b_addr[nseen];
            if (bus.oAck) begin
                ack_t[nseen] = t;
                ack_d[nseen] = bus.oRData;
                nseen++;
                if (nseen < 3) bus.iAddr = b2b_addr[nseen];
                else bus.iReq = 1'b0;
            end
        end
        bus.iReq = 1'b0;
        check("b2b_nack", nseen, 3);
        if (nseen == 3) begin
            check("b2b_gap1", ack_t[1] - ack_t[0], 5);
            check("b2b_gap2", ack_t[2] - ack_t[1], 5);
            check("b2b_d0", ack_d[0], b2b_exp[0]);
            check("b2b_d1", ack_d[1], b2b_exp[1]);
            check("b2b_d2", ack_d[2], b2b_exp[2]);
        end

        txn(1'b1, 16'h0005, 1'b1, 8'h42, rd, lat, nack, nbusy, err);
        check("w0_wr_lat", lat, 2);
        txn(1'b1, 16'h0005, 1'b0, 8'h00, rd, lat, nack, nbusy, err);
        check("w0_rd_lat",  lat,   2);
        check("w0_rd_nack", nack,  1);
        check("w0_rd_busy", nbusy, 2);
        check("w0_rd_rd",   rd,    8'h42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
